// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-size round counts and round-controller state encoding
package aes_pkg;

    localparam int AES_BLOCK_LEN = 128;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam int ROUND_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_OUTPUT   = 2'd3
    } ctrl_state_t;

    function automatic logic nr_is_legal(input int nr);
        return (nr == NR_128) || (nr == NR_192) || (nr == NR_256);
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - round sequencer: holds the AES state and steps it through rounds 0..NR
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DATA_LEN = AES_BLOCK_LEN,
    parameter int NR       = NR_128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_LEN-1:0]    in_data,
    input  logic                   key_ready,
    input  logic                   abort,
    output logic [DATA_LEN-1:0]    dp_state,
    output logic                   dp_data_valid,
    output logic                   dp_key_valid,
    output logic [ROUND_IDX_W-1:0] round_key_idx,
    output logic                   round_fn_bypass,
    output logic                   mix_bypass,
    input  logic [DATA_LEN-1:0]    dp_result,
    input  logic                   dp_result_valid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LEN-1:0]    out_data,
    output logic                   busy,
    output logic                   proto_err
);

    localparam logic                   NR_OK  = nr_is_legal(NR);
    localparam logic [ROUND_IDX_W-1:0] NR_IDX = ROUND_IDX_W'(NR);

    if (!NR_OK || (DATA_LEN != AES_BLOCK_LEN)) begin : g_bad_cfg
        $error("aes_round_ctrl: unsupported NR or DATA_LEN");
    end

    ctrl_state_t            st, st_nx;
    logic [ROUND_IDX_W-1:0] round_q, round_nx;
    logic [DATA_LEN-1:0]    state_q, state_nx;
    logic                   proto_err_q;
    logic                   stray_result;
    logic                   in_round;

    // A result arriving outside WAIT_RES has no owner; it is flagged and dropped.
    assign stray_result = dp_result_valid && (st != ST_WAIT_RES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= ST_IDLE;
            round_q     <= '0;
            state_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            st          <= st_nx;
            round_q     <= round_nx;
            state_q     <= state_nx;
            proto_err_q <= proto_err_q | stray_result | ~NR_OK;
        end
    end

    always_comb begin
        st_nx    = st;
        round_nx = round_q;
        state_nx = state_q;
        if (abort) begin
            st_nx    = ST_IDLE;
            round_nx = '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_nx = in_data;
                        round_nx = '0;
                        st_nx    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (key_ready) begin
                        st_nx = ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (dp_result_valid) begin
                        state_nx = dp_result;
                        if (round_q >= NR_IDX) begin
                            st_nx = ST_OUTPUT;
                        end else begin
                            round_nx = round_q + 4'd1;
                            st_nx    = ST_ISSUE;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        st_nx = ST_IDLE;
                    end
                end
                default: st_nx = ST_IDLE;
            endcase
        end
    end

    // Round selectors are held for the whole issue/wait pair so the datapath sees them stable.
    assign in_round        = (st == ST_ISSUE) || (st == ST_WAIT_RES);
    assign round_key_idx   = in_round ? round_q : '0;
    assign round_fn_bypass = in_round && (round_q == '0);
    assign mix_bypass      = in_round && (round_q == NR_IDX);

    assign dp_data_valid = (st == ST_ISSUE) && key_ready && !abort;
    assign dp_key_valid  = dp_data_valid;
    assign dp_state      = state_q;

    assign in_ready  = (st == ST_IDLE);
    assign busy      = (st != ST_IDLE);
    assign out_valid = (st == ST_OUTPUT);
    assign out_data  = out_valid ? state_q : '0;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - round controller with a behavioural AES datapath and reference encryptor
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR = NR_128;
    localparam logic [127:0] KAT_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, key_ready, abort;
    logic [127:0] in_data, dp_state, dp_result, out_data;
    logic         dp_data_valid, dp_key_valid, round_fn_bypass, mix_bypass;
    logic [3:0]   round_key_idx;
    logic         dp_result_valid, out_valid, out_ready, busy, proto_err;

    aes_round_ctrl #(.DATA_LEN(128), .NR(NR)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_ready(key_ready), .abort(abort), .dp_state(dp_state), .dp_data_valid(dp_data_valid),
        .dp_key_valid(dp_key_valid), .round_key_idx(round_key_idx), .round_fn_bypass(round_fn_bypass),
        .mix_bypass(mix_bypass), .dp_result(dp_result), .dp_result_valid(dp_result_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk [15];
    logic [127:0] cur_key;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[127-8*i -: 8] = sbox[x[127-8*i -: 8]];
        return y;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
        return y;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            y[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            y[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            y[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            y[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return y;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endfunction

    // Whole-block FIPS-197 cipher, independent of how the controller sequences it.
    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ round_key(key, 0);
        for (int r = 1; r <= NR; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r != NR) s = mix_columns(s);
            s = s ^ round_key(key, r);
        end
        return s;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic fb, input logic mb);
        if (fb) return s;
        s = shift_rows(sub_bytes(s));
        if (!mb) s = mix_columns(s);
        return s;
    endfunction

    // Stub round function followed by the registered round-key-XOR stage.
    logic         stray = 1'b0;
    logic         dp_vld_q;
    logic [127:0] dp_res_q;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_vld_q <= 1'b0;
            dp_res_q <= '0;
        end else begin
            dp_vld_q <= dp_data_valid & dp_key_valid;
            if (dp_data_valid && dp_key_valid)
                dp_res_q <= round_fn(dp_state, round_fn_bypass, mix_bypass) ^ rk[round_key_idx];
        end
    end
    assign dp_result_valid = dp_vld_q | stray;
    assign dp_result       = stray ? 128'h0badc0de0badc0de0badc0de0badc0d : dp_res_q;

    int   log_idx[$];
    int   log_cyc[$];
    logic log_fb[$];
    logic log_mb[$];
    logic log_kv[$];
    always @(negedge clk) begin
        if (reset && dp_data_valid) begin
            log_idx.push_back(int'(round_key_idx));
            log_cyc.push_back(cyc);
            log_fb.push_back(round_fn_bypass);
            log_mb.push_back(mix_bypass);
            log_kv.push_back(dp_key_valid);
        end
    end

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic [127:0] key);
        cur_key = key;
        for (int k = 0; k <= NR; k++) rk[k] = round_key(key, k);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":ctl"}, {in_ready, dp_data_valid, dp_key_valid, round_fn_bypass, mix_bypass,
                              out_valid, busy, proto_err, round_key_idx}, {8'b1000_0000, 4'd0});
        check({tag, ":dp_state"}, dp_state, 128'h0);
        check({tag, ":out_data"}, out_data, 128'h0);
    endtask

    task automatic do_block(input logic [127:0] pt, input int stall_round, input int stall_len,
                            input int bp_len, input logic [127:0] exp_ct, input string tag);
        int t0, t_out, exp_lat, n, exp_c, ns;
        logic got;
        logic [127:0] held;
        log_idx.delete(); log_cyc.delete(); log_fb.delete(); log_mb.delete(); log_kv.delete();
        next_cycle();
        in_valid  = 1'b1;
        in_data   = pt;
        out_ready = (bp_len == 0);
        key_ready = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check({tag, ":in_ready"}, in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        got = 1'b0;
        n = 0;
        while (!got && n < 300) begin
            key_ready = !(stall_round >= 0 && cyc >= t0 + 1 + 2*stall_round &&
                          cyc < t0 + 1 + 2*stall_round + stall_len);
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else begin
                next_cycle();
                n++;
            end
        end
        key_ready = 1'b1;
        t_out   = got ? cyc : -1;
        exp_lat = t0 + 3 + 2*NR + (stall_round >= 0 ? stall_len : 0);
        check({tag, ":latency"}, t_out, exp_lat);
        check({tag, ":out_data"}, out_data, exp_ct);
        held = exp_ct;
        if (bp_len > 0) begin
            for (int j = 1; j < bp_len; j++) begin
                next_cycle();
                @(negedge clk);
                check({tag, ":hold"}, {in_ready, out_valid, out_data}, {1'b0, 1'b1, held});
            end
            next_cycle();
            out_ready = 1'b1;
            @(negedge clk);
            check({tag, ":hold_last"}, {in_ready, out_valid, out_data}, {1'b0, 1'b1, held});
        end
        next_cycle();
        @(negedge clk);
        check({tag, ":idle_after"}, {busy, in_ready, out_valid}, 3'b010);
        check({tag, ":n_strobes"}, log_idx.size(), NR + 1);
        ns = (log_idx.size() < NR + 1) ? log_idx.size() : NR + 1;
        for (int k = 0; k < ns; k++) begin
            exp_c = t0 + 1 + 2*k + ((stall_round >= 0 && k >= stall_round) ? stall_len : 0);
            check($sformatf("%s:strobe%0d", tag, k),
                  {32'(log_idx[k]), 32'(log_cyc[k]), log_fb[k], log_mb[k], log_kv[k]},
                  {32'(k), 32'(exp_c), (k == 0), (k == NR), 1'b1});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ov_cnt, sr, sl, bp;
        logic [127:0] pt, held;
        logic [7:0] inv;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        set_key(KAT_KEY);

        in_valid = 1'b0; in_data = '0; key_ready = 1'b1; abort = 1'b0; out_ready = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 check_reset_vals("reset");
        repeat (2) next_cycle();
        reset = 1'b1;

        do_block(KAT_PT, -1, 0, 0, KAT_CT, "kat");
        do_block(KAT_PT, 3, 5, 0, KAT_CT, "stall");
        do_block(KAT_PT, -1, 0, 7, KAT_CT, "backpressure");

        // Abort lands in round 6's WAIT_RES, the same cycle its result returns.
        next_cycle();
        in_valid = 1'b1;
        in_data  = KAT_PT;
        t0 = cyc;
        next_cycle();
        in_valid = 1'b0;
        while (cyc < t0 + 14) next_cycle();
        abort = 1'b1;
        @(negedge clk);
        check("abort:pre", {busy, dp_data_valid, round_key_idx}, {1'b1, 1'b0, 4'd6});
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("abort:idle", {busy, in_ready}, 2'b01);
        ov_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            next_cycle();
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("abort:no_out_valid", ov_cnt, 0);
        check("abort:proto_err", proto_err, 0);
        do_block(KAT_PT, -1, 0, 0, KAT_CT, "after_abort");

        pt = {$urandom, $urandom, $urandom, $urandom};
        next_cycle();
        in_valid = 1'b1;
        in_data  = pt;
        t0 = cyc;
        next_cycle();
        in_valid = 1'b0;
        while (cyc < t0 + 4) next_cycle();
        @(negedge clk);
        check("rst_mid:pre", {busy, round_key_idx}, {1'b1, 4'd1});
        #2 reset = 1'b0;
        #1 check_reset_vals("rst_mid");
        repeat (2) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid:after", {in_ready, busy}, 2'b10);

        for (int b = 0; b < 6; b++) begin
            set_key({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            sr = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, NR));
            sl = int'($urandom_range(1, 4));
            bp = int'($urandom_range(0, 3));
            do_block(pt, sr, sl, bp, aes_encrypt(pt, cur_key), $sformatf("rand%0d", b));
        end

        next_cycle();
        held  = dp_state;
        stray = 1'b1;
        next_cycle();
        stray = 1'b0;
        @(negedge clk);
        check("stray:set", {proto_err, busy, dp_state}, {1'b1, 1'b0, held});
        repeat (5) next_cycle();
        @(negedge clk);
        check("stray:sticky", proto_err, 1);
        pt = {$urandom, $urandom, $urandom, $urandom};
        do_block(pt, -1, 0, 0, aes_encrypt(pt, cur_key), "post_stray");
        check("stray:still", proto_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Round sequencer for the iterative AES encryption datapath.
- Accepts one plaintext block over a valid/ready handshake and holds the AES state register.
- For round 0 it drives the state straight into the round-key-XOR stage. For each of rounds 1..NR it drives the round function, then the round-key-XOR stage.
- Selects the round-key index, bypasses MixColumns in the final round, and presents the ciphertext on an output valid/ready handshake.

Parameters:
- DATA_LEN, 128, block width in bits; only 128 is supported.
- NR, 10, number of AES rounds; legal values 10/12/14 (AES-128/192/256).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  plaintext block valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  DATA_LEN  plaintext block.
- key_ready  in  1  round-key store holds a valid expanded key.
- abort  in  1  synchronous abort of the block in flight.
- dp_state  out  DATA_LEN  current AES state, sent to the datapath.
- dp_data_valid  out  1  data-valid strobe to the round-key-XOR stage.
- dp_key_valid  out  1  key-valid strobe to the round-key-XOR stage.
- round_key_idx  out  4  index of the round key to apply (0..NR).
- round_fn_bypass  out  1  high in round 0: SubBytes, ShiftRows and MixColumns are all skipped.
- mix_bypass  out  1  high in round NR: MixColumns is skipped.
- dp_result  in  DATA_LEN  registered output of the round-key-XOR stage.
- dp_result_valid  in  1  dp_result valid (one cycle after the strobes).
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  DATA_LEN  ciphertext.
- busy  out  1  high in any state other than IDLE.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs are 0, except in_ready=1 (state IDLE). The state register, round counter and proto_err are cleared. Reset is asynchronous and may arrive mid-block; the block in flight is discarded.
- State machine states: IDLE, ISSUE, WAIT_RES, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid, load the state register with in_data, set round=0, go to ISSUE.
- ISSUE:
  - If key_ready=1: dp_data_valid=dp_key_valid=1 for exactly one cycle; round_key_idx=round; round_fn_bypass=(round==0); mix_bypass=(round==NR); go to WAIT_RES.
  - If key_ready=0: stay in ISSUE with both strobes low (stall). There is no timeout.
- WAIT_RES:
  - On dp_result_valid, capture dp_result into the state register.
  - If round==NR, go to OUTPUT; otherwise round++ and go to ISSUE.
  - Without dp_result_valid, wait indefinitely.
- OUTPUT:
  - out_valid=1 and out_data=state, both held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE. in_ready rises on the next cycle; a block accepted in IDLE in the same cycle as the transfer is not supported.
- dp_state always equals the state register.
- round_key_idx, round_fn_bypass and mix_bypass are stable throughout ISSUE and WAIT_RES.
- Latency with a 1-cycle datapath: handshake at cycle T → out_valid at T+3+2*NR (T+23 for NR=10).
- abort: in any state it forces IDLE on the next edge. It clears out_valid and the round counter; the state contents are don't-care. abort takes priority over every other transition.
- proto_err:
  - Set when dp_result_valid=1 in any state other than WAIT_RES.
  - Set when NR is not 10/12/14; this check is done at elaboration and also asserted at runtime.
  - Cleared only by reset. A stray dp_result is ignored and does not disturb the state.
- Round counter: 4 bits, never exceeds NR, no wrap.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLOCK_LEN=128;
  - the legal NR constants NR_128=10, NR_192=12, NR_256=14;
  - the FSM state encoding (IDLE/ISSUE/WAIT_RES/OUTPUT, 2-bit);
  - a ROUND_IDX_W=4 constant.
- No sub-module is needed. The FSM, round counter and state register live in one module, and the bench pairs it with the existing round-key-XOR stage plus a stub round function.

Test Plan:
- FIPS-197 Appendix B, NR=10:
  - Stimulus: plaintext 3243f6a8885a308d313198a2e0370734 with key 2b7e151628aed2a6abf7158809cf4f3c. Keep out_ready=1.
  - Required response: out_data=3925841d02dc09fbdc118597196a0b32 at T+23. Exactly 11 strobe pulses with idx 0..10; round_fn_bypass only on idx 0; mix_bypass only on idx 10.
- key_ready stall:
  - Stimulus: drop key_ready for 5 cycles during round 3's ISSUE.
  - Required response: no strobes during the stall; result still correct; out_valid delayed by exactly 5 cycles.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 7 cycles.
  - Required response: out_valid and out_data held stable; in_ready=0 throughout; return to IDLE one cycle after out_ready=1.
- Abort in round 6:
  - Stimulus: pulse abort during round 6, then submit the Appendix B block again.
  - Required response: busy=0 on the next cycle; no out_valid for the aborted block; the new block completes with the correct ciphertext.
- Reset mid-operation:
  - Stimulus: assert reset in WAIT_RES.
  - Required response: all outputs reach their reset values immediately (asynchronously); in_ready=1 after release.
- Stray result:
  - Stimulus: pulse dp_result_valid in IDLE.
  - Required response: proto_err=1 and stays high; the following block is unaffected.
